// File: rtl/cic_decim_mc_if.sv
// Sample/config bundle for the multi-channel CIC decimator.
// master drives config and input samples; slave is the decimator side.
interface cic_decim_mc_if #(
    parameter int NCH       = 2,
    parameter int IN_WIDTH  = 18,
    parameter int OUT_WIDTH = 18
);
    logic [7:0]               decimation;
    logic [5:0]               out_shift;
    logic                     in_strobe;
    logic [NCH*IN_WIDTH-1:0]  in_data;
    logic                     out_strobe;
    logic [NCH*OUT_WIDTH-1:0] out_data;
    logic                     sat;

    modport master (
        output decimation, out_shift, in_strobe, in_data,
        input  out_strobe, out_data, sat
    );

    modport slave (
        input  decimation, out_shift, in_strobe, in_data,
        output out_strobe, out_data, sat
    );
endinterface

// File: rtl/cic_decim_mc.sv
// Multi-channel CIC decimator with runtime ratio/shift, pipelined combs,
// round-half-up saturating output and automatic flush on config change.
module cic_decim_mc #(
    parameter int STAGES    = 3,
    parameter int NCH       = 2,
    parameter int IN_WIDTH  = 18,
    parameter int OUT_WIDTH = 18,
    parameter int MAX_DEC   = 40,
    parameter int ACC_WIDTH = 40
) (
    input logic           clock,
    input logic           reset,
    cic_decim_mc_if.slave bus
);

    localparam int SW = $clog2(STAGES + 1);
    localparam logic [7:0] MAX_R = 8'(MAX_DEC);
    localparam logic [SW-1:0] SETTLE_INIT = SW'(STAGES);
    localparam logic signed [ACC_WIDTH:0] ONE = 1;
    localparam logic signed [ACC_WIDTH:0] OUT_MAX = (ONE <<< (OUT_WIDTH - 1)) - ONE;
    localparam logic signed [ACC_WIDTH:0] OUT_MIN = -(ONE <<< (OUT_WIDTH - 1));

    // Returns {saturated, value}: arithmetic shift, round half up, clamp.
    function automatic logic [OUT_WIDTH:0] round_sat(input logic signed [ACC_WIDTH-1:0] v,
                                                     input logic [5:0] sh);
        logic signed [ACC_WIDTH:0] ext;
        logic signed [ACC_WIDTH:0] half;
        logic signed [ACC_WIDTH:0] r;
        logic [OUT_WIDTH:0] res;
        ext  = (ACC_WIDTH + 1)'(v);
        half = (sh == 6'd0) ? '0 : (ONE <<< (sh - 6'd1));
        r    = (ext + half) >>> sh;
        if (r > OUT_MAX)
            res = {1'b1, OUT_MAX[OUT_WIDTH-1:0]};
        else if (r < OUT_MIN)
            res = {1'b1, OUT_MIN[OUT_WIDTH-1:0]};
        else
            res = {1'b0, r[OUT_WIDTH-1:0]};
        return res;
    endfunction

    logic [7:0]                  dec_clamped;
    logic [7:0]                  dec_lat;
    logic [5:0]                  shift_lat;
    logic                        cfg_change;
    logic [7:0]                  cnt_p0;
    logic                        vld_p0;
    logic signed [ACC_WIDTH-1:0] sample [NCH];
    logic signed [ACC_WIDTH-1:0] integ_p0 [NCH][STAGES];
    logic signed [ACC_WIDTH-1:0] comb_in [NCH][STAGES];
    logic signed [ACC_WIDTH-1:0] comb_nxt [NCH][STAGES];
    logic signed [ACC_WIDTH-1:0] comb_p1 [NCH][STAGES];
    logic signed [ACC_WIDTH-1:0] dly_p1 [NCH][STAGES];
    logic [OUT_WIDTH:0]          rs [NCH];
    logic [NCH*OUT_WIDTH-1:0]    data_nxt;
    logic                        sat_nxt;
    logic [SW-1:0]               settle;
    logic                        vld_p1;
    logic                        sat_p1;
    logic [NCH*OUT_WIDTH-1:0]    data_p1;

    always_comb begin
        dec_clamped = bus.decimation;
        if (bus.decimation < 8'd2)
            dec_clamped = 8'd2;
        else if (bus.decimation > MAX_R)
            dec_clamped = MAX_R;
    end

    assign cfg_change = (dec_clamped != dec_lat) || (bus.out_shift != shift_lat);

    always_comb begin
        for (int c = 0; c < NCH; c++)
            sample[c] = ACC_WIDTH'(signed'(bus.in_data[c*IN_WIDTH +: IN_WIDTH]));
    end

    // Config latch and frame counter; a reload flushes the whole datapath.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dec_lat   <= 8'd2;
            shift_lat <= 6'd0;
            cnt_p0    <= 8'd0;
            vld_p0    <= 1'b0;
        end else if (cfg_change) begin
            dec_lat   <= dec_clamped;
            shift_lat <= bus.out_shift;
            cnt_p0    <= 8'd0;
            vld_p0    <= 1'b0;
        end else begin
            vld_p0 <= 1'b0;
            if (bus.in_strobe) begin
                if (cnt_p0 == dec_lat - 8'd1) begin
                    cnt_p0 <= 8'd0;
                    vld_p0 <= 1'b1;
                end else begin
                    cnt_p0 <= cnt_p0 + 8'd1;
                end
            end
        end
    end

    // Stage p0: integrators at the input rate, wrapping modulo 2^ACC_WIDTH.
    always_ff @(posedge clock or posedge reset) begin
        if (reset || cfg_change) begin
            for (int c = 0; c < NCH; c++)
                for (int k = 0; k < STAGES; k++)
                    integ_p0[c][k] <= '0;
        end else if (bus.in_strobe) begin
            for (int c = 0; c < NCH; c++) begin
                integ_p0[c][0] <= integ_p0[c][0] + sample[c];
                for (int k = 1; k < STAGES; k++)
                    integ_p0[c][k] <= integ_p0[c][k] + integ_p0[c][k-1];
            end
        end
    end

    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            comb_in[c][0] = integ_p0[c][STAGES-1];
            for (int k = 1; k < STAGES; k++)
                comb_in[c][k] = comb_p1[c][k-1];
            for (int k = 0; k < STAGES; k++)
                comb_nxt[c][k] = comb_in[c][k] - dly_p1[c][k];
        end
    end

    always_comb begin
        sat_nxt  = 1'b0;
        data_nxt = '0;
        for (int c = 0; c < NCH; c++) begin
            rs[c] = round_sat(comb_nxt[c][STAGES-1], shift_lat);
            data_nxt[c*OUT_WIDTH +: OUT_WIDTH] = rs[c][OUT_WIDTH-1:0];
            sat_nxt = sat_nxt | rs[c][OUT_WIDTH];
        end
    end

    // Stage p1: combs run once per dump; the output register samples the last comb's new value.
    always_ff @(posedge clock or posedge reset) begin
        if (reset || cfg_change) begin
            for (int c = 0; c < NCH; c++)
                for (int k = 0; k < STAGES; k++) begin
                    comb_p1[c][k] <= '0;
                    dly_p1[c][k]  <= '0;
                end
        end else if (vld_p0) begin
            for (int c = 0; c < NCH; c++)
                for (int k = 0; k < STAGES; k++) begin
                    comb_p1[c][k] <= comb_nxt[c][k];
                    dly_p1[c][k]  <= comb_in[c][k];
                end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            settle  <= SETTLE_INIT;
            vld_p1  <= 1'b0;
            sat_p1  <= 1'b0;
            data_p1 <= '0;
        end else if (cfg_change) begin
            settle <= SETTLE_INIT;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= 1'b0;
            if (vld_p0) begin
                data_p1 <= data_nxt;
                sat_p1  <= sat_nxt;
                if (settle != '0)
                    settle <= settle - 1'b1;
                else
                    vld_p1 <= 1'b1;
            end
        end
    end

    assign bus.out_strobe = vld_p1;
    assign bus.out_data   = data_p1;
    assign bus.sat        = sat_p1;

endmodule

// File: tb/tb_cic_decim_mc.sv
// Bench for cic_decim_mc: directed spec scenarios plus randomized DC segments,
// each compared with a frame-level model of timing and settled DC gain.
module tb_cic_decim_mc;

    localparam int S   = 3;
    localparam int IW  = 18;
    localparam int OW  = 18;
    localparam int MXD = 40;
    localparam int SETTLED = 2 * S + 4;

    logic clock = 1'b0;
    logic reset = 1'b1;

    cic_decim_mc_if #(.NCH(2), .IN_WIDTH(IW), .OUT_WIDTH(OW)) bus ();

    cic_decim_mc #(
        .STAGES(S), .NCH(2), .IN_WIDTH(IW), .OUT_WIDTH(OW), .MAX_DEC(MXD), .ACC_WIDTH(40)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;

    int passed = 0;
    int total  = 0;
    int failed = 0;

    // Model state: latched config, input count in frame, completed frames since flush.
    int lat_r, lat_sh, mcnt, frames, prev_done;
    int cur_dec, cur_sh, dc0, dc1;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int clamp_dec(input int d);
        return (d < 2) ? 2 : ((d > MXD) ? MXD : d);
    endfunction

    // Settled DC output: dc * R^S / 2^sh, rounded half up, saturated.
    function automatic void expect_ch(input int dc, input int r, input int sh,
                                      output logic signed [63:0] q, output bit s);
        longint v, d, n, t;
        v = dc;
        repeat (S) v = v * r;
        d = longint'(1) << sh;
        n = v + d / 2;
        t = n / d;
        if ((n % d != 0) && (n < 0)) t = t - 1;
        s = 1'b0;
        if (t > 131071) begin t = 131071; s = 1'b1; end
        if (t < -131072) begin t = -131072; s = 1'b1; end
        q = t;
    endfunction

    function automatic void model_reset();
        lat_r = 2; lat_sh = 0; mcnt = 0; frames = 0; prev_done = 0;
    endfunction

    task automatic tick(input bit strobe);
        bit exp_strobe;
        int exp_frame;
        logic signed [63:0] e0, e1;
        bit s0, s1;
        bus.in_strobe  = strobe;
        bus.decimation = 8'(cur_dec);
        bus.out_shift  = 6'(cur_sh);
        bus.in_data    = {IW'(dc1), IW'(dc0)};
        @(posedge clock);
        exp_frame  = prev_done;
        exp_strobe = (prev_done > S);
        prev_done  = 0;
        if (clamp_dec(cur_dec) != lat_r || cur_sh != lat_sh) begin
            lat_r = clamp_dec(cur_dec); lat_sh = cur_sh;
            mcnt = 0; frames = 0; exp_strobe = 1'b0;
        end else if (strobe) begin
            mcnt++;
            if (mcnt == lat_r) begin
                mcnt = 0; frames++; prev_done = frames;
            end
        end
        #1;
        check("out_strobe", 64'(bus.out_strobe), 64'(exp_strobe));
        if (exp_strobe && exp_frame >= SETTLED) begin
            expect_ch(dc0, lat_r, lat_sh, e0, s0);
            expect_ch(dc1, lat_r, lat_sh, e1, s1);
            check("out_data_ch0", 64'(signed'(bus.out_data[0 +: OW])), e0);
            check("out_data_ch1", 64'(signed'(bus.out_data[OW +: OW])), e1);
            check("sat", 64'(bus.sat), 64'(s0 | s1));
        end
    endtask

    // New DC segment; forces a flush if the config would otherwise be unchanged.
    task automatic segment(input int dec, input int sh, input int d0, input int d1,
                           input int nfr, input bit gaps);
        int limit;
        if (clamp_dec(dec) == lat_r && sh == lat_sh) begin
            cur_sh = sh ^ 1;
            tick(1'b0);
        end
        cur_dec = dec; cur_sh = sh; dc0 = d0; dc1 = d1;
        tick(1'b1);
        limit = nfr * clamp_dec(dec) * 6 + 20;
        for (int i = 0; i < limit && frames < nfr; i++)
            tick(gaps ? 1'($urandom_range(0, 1)) : 1'b1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_strobe"}, 64'(bus.out_strobe), 64'd0);
        check({tag, "_data"}, 64'(bus.out_data), 64'd0);
        check({tag, "_sat"}, 64'(bus.sat), 64'd0);
    endtask

    initial begin
        cur_dec = 10; cur_sh = 10; dc0 = 1000; dc1 = 1000;
        bus.in_strobe = 1'b0; bus.decimation = 8'd10; bus.out_shift = 6'd10;
        bus.in_data = '0;
        model_reset();
        #12;
        check_zero("reset");
        reset = 1'b0;

        // Reset/settle, ratio 4, rounding, saturation.
        segment(10, 10, 1000, 1000, 14, 1'b0);
        segment(4, 6, -1000, -1000, 14, 1'b0);
        segment(2, 4, 3, -3, 14, 1'b0);
        segment(10, 0, 1000, -1000, 14, 1'b0);
        segment(10, 0, 1000, 5, 14, 1'b0);

        // Mid-frame ratio change 10 -> 4.
        segment(10, 10, 1000, 1000, 6, 1'b0);
        repeat (3) tick(1'b1);
        segment(4, 6, -1000, -1000, 14, 1'b0);

        // Out-of-range ratios clamp.
        segment(1, 3, 700, -900, 14, 1'b1);
        segment(200, 15, -20000, 31000, 14, 1'b0);

        // Asynchronous reset between edges, mid-frame.
        segment(10, 10, 1000, 1000, 5, 1'b0);
        repeat (4) tick(1'b1);
        #2 reset = 1'b1;
        #1 check_zero("async_reset");
        #1 reset = 1'b0;
        model_reset();
        for (int i = 0; i < 160; i++) tick(1'b1);

        // Randomized segments.
        for (int n = 0; n < 6; n++)
            segment(int'($urandom_range(1, 45)), int'($urandom_range(0, 22)),
                    int'($urandom_range(0, 262143)) - 131072,
                    int'($urandom_range(0, 262143)) - 131072,
                    13, 1'($urandom_range(0, 1)));

        repeat (3) tick(1'b0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
